vga_timing_ctrl: RTL



---
 rtl/vga_timing_if.sv | 22 ++
 rtl/vga_timing_ctrl.sv | 91 +++++++++
 2 files changed

// File: rtl/vga_timing_if.sv
// Signal bundle between the VGA timing controller and the picture generator / display side.
interface vga_timing_if;
    logic [15:0] pix_data;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        hsync;
    logic        vsync;
    logic [15:0] rgb;
    logic        rgb_valid;
    logic        frame_start;
    logic [15:0] frame_cnt;

    modport master (
        input  pix_data,
        output pix_x, pix_y, hsync, vsync, rgb, rgb_valid, frame_start, frame_cnt
    );

    modport slave (
        output pix_data,
        input  pix_x, pix_y, hsync, vsync, rgb, rgb_valid, frame_start, frame_cnt
    );
endinterface

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing: h/v counters, sync decode, early pixel request and RGB gating,
// plus frame bookkeeping. Defaults give 640x480@60 Hz from a 25 MHz pixel clock.
module vga_timing_ctrl #(
    parameter int   H_SYNC   = 96,
    parameter int   H_BACK   = 48,
    parameter int   H_VALID  = 640,
    parameter int   H_FRONT  = 16,
    parameter int   V_SYNC   = 2,
    parameter int   V_BACK   = 33,
    parameter int   V_VALID  = 480,
    parameter int   V_FRONT  = 10,
    parameter int   DATA_LAT = 1,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic  vga_clk,
    input  logic  sys_rst_n,
    vga_timing_if.master vif
);
    localparam logic [9:0] H_LAST    = 10'(H_SYNC + H_BACK + H_VALID + H_FRONT - 1);
    localparam logic [9:0] V_LAST    = 10'(V_SYNC + V_BACK + V_VALID + V_FRONT - 1);
    localparam logic [9:0] H_SYNC_END = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_END = 10'(V_SYNC);
    localparam logic [9:0] H_ACT_BEG = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] H_ACT_END = 10'(H_SYNC + H_BACK + H_VALID);
    localparam logic [9:0] V_ACT_BEG = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] V_ACT_END = 10'(V_SYNC + V_BACK + V_VALID);
    // The request window leads the active window by the generator's latency.
    localparam logic [9:0] H_REQ_BEG = 10'(H_SYNC + H_BACK - DATA_LAT);
    localparam logic [9:0] H_REQ_END = 10'(H_SYNC + H_BACK + H_VALID - DATA_LAT);

    logic [9:0]  cnt_h;
    logic [9:0]  cnt_v;
    logic [15:0] frame_cnt;
    logic        h_active;
    logic        v_active;
    logic        h_req;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_h     <= '0;
            cnt_v     <= '0;
            frame_cnt <= '0;
        end else if (cnt_h == H_LAST) begin
            cnt_h <= '0;
            if (cnt_v == V_LAST) begin
                cnt_v     <= '0;
                frame_cnt <= frame_cnt + 16'd1;
            end else begin
                cnt_v <= cnt_v + 10'd1;
            end
        end else begin
            cnt_h <= cnt_h + 10'd1;
        end
    end

    assign h_active = (cnt_h >= H_ACT_BEG) && (cnt_h < H_ACT_END);
    assign v_active = (cnt_v >= V_ACT_BEG) && (cnt_v < V_ACT_END);
    assign h_req    = (cnt_h >= H_REQ_BEG) && (cnt_h < H_REQ_END);

    // NOTE: every output gets a default first, so no path through the block
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        vif.hsync       = ~SYNC_POL;
        vif.vsync       = ~SYNC_POL;
        vif.pix_x       = 10'h3FF;
        vif.pix_y       = 10'h3FF;
        vif.rgb_valid   = 1'b0;
        vif.rgb         = 16'h0000;
        vif.frame_start = 1'b0;

        if (cnt_h < H_SYNC_END) vif.hsync = SYNC_POL;
        if (cnt_v < V_SYNC_END) vif.vsync = SYNC_POL;

        // Subtractions only happen inside the request window, so they never underflow.
        if (h_req && v_active) begin
            vif.pix_x = cnt_h - H_REQ_BEG;
            vif.pix_y = cnt_v - V_ACT_BEG;
        end

        if (h_active && v_active) begin
            vif.rgb_valid = 1'b1;
            vif.rgb       = vif.pix_data;
        end

        if (cnt_h == 10'd0 && cnt_v == 10'd0) vif.frame_start = 1'b1;
    end

    assign vif.frame_cnt = frame_cnt;
endmodule
